// File: rtl/aes_round_engine.sv
// aes_round_engine -- iterative AES-128 encryption, one round per clock.
//
// Consumes the fully expanded key schedule (round key r at keys[1407-128*r -: 128])
// and a 128-bit plaintext block, and returns the ciphertext ten clocks after the
// block is accepted. Byte 0 of every 128-bit block sits in bits [127:120]; bytes
// are column-major, so byte (row r, column c) is byte r + 4*c.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     plaintext/keys offered          in_ready   engine idle, can accept
//   plaintext    128-bit input block             keys       1408-bit key schedule
//   out_valid    ciphertext available            out_ready  consumer takes ciphertext
//   ciphertext   128-bit result (held after hand-off)
//   busy         high while a block is in flight or waiting to be taken
//
// Build option: define AES_KEY_LATCH_EN to copy the key schedule into a local
// register when a block is accepted, so the keys input may change mid-block.
// Without it the keys input must stay stable until the result is presented.

// Four parallel S-box lookups on one 32-bit column.
module aes_sub_word (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);
  // FIPS-197 S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'h7ff - {b, 3'b000};
    return SBOX[idx -: 8];
  endfunction

  assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                   sbox(word_i[15:8]),  sbox(word_i[7:0])};
endmodule

module aes_round_engine #(
  parameter  int NR       = 10,
  localparam int KSCHED_W = 128 * (NR + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        plaintext,
  input  logic [KSCHED_W-1:0] keys,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        ciphertext,
  output logic                busy
);

  if (NR != 10) begin : g_nr_check
    $error("aes_round_engine: only NR=10 (AES-128) is supported");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_e;
  typedef logic [0:15][7:0] block_t;   // element 0 = byte 0 = bits [127:120]

  localparam logic [3:0] LAST_RND = 4'(NR);

  fsm_e         fsm_q;
  logic [3:0]   rnd_q;
  logic [127:0] state_q;
  logic [127:0] ct_q;
  logic         in_ready_q, out_valid_q, busy_q;

  // ---------------------------------------------------------------------------
  // Round transforms
  // ---------------------------------------------------------------------------
  // Row r rotates left by r: new (r,c) takes old (r,(c+r) mod 4).
  function automatic block_t shift_rows(input block_t s);
    return {s[0],  s[5],  s[10], s[15],
            s[4],  s[9],  s[14], s[3],
            s[8],  s[13], s[2],  s[7],
            s[12], s[1],  s[6],  s[11]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiplication by the circulant matrix {02 03 01 01}; 3*a = xtime(a)^a.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // ---------------------------------------------------------------------------
  // Key schedule source and per-round key select
  // ---------------------------------------------------------------------------
  logic [KSCHED_W-1:0] keys_src;
  logic                accept;

  assign accept = in_valid && (fsm_q == S_IDLE);

`ifdef AES_KEY_LATCH_EN
  logic [KSCHED_W-1:0] keys_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) keys_q <= '0;
    else if (accept) keys_q <= keys;
  end

  assign keys_src = keys_q;
`else
  assign keys_src = keys;
`endif

  logic [127:0] rk [0:NR];
  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign rk[r] = keys_src[KSCHED_W-1-128*r -: 128];
  end

  // ---------------------------------------------------------------------------
  // One round of datapath: SubBytes -> ShiftRows -> (MixColumns) -> AddRoundKey
  // ---------------------------------------------------------------------------
  logic [127:0] sb, sr, mc, state_d;

  for (genvar c = 0; c < 4; c++) begin : g_col
    aes_sub_word u_sub (
      .word_i (state_q[127-32*c -: 32]),
      .word_o (sb[127-32*c -: 32])
    );
    assign mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
  end

  assign sr      = shift_rows(sb);
  assign state_d = ((rnd_q == LAST_RND) ? sr : mc) ^ rk[rnd_q];

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every register here is assigned with <= so all updates within one edge
  // see the pre-edge values; blocking = in a clocked block creates order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= S_IDLE;
      rnd_q       <= '0;
      state_q     <= '0;
      ct_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (fsm_q)
        S_IDLE: begin
          if (in_valid) begin
            // Round key 0 is taken straight from the port: the local copy (when
            // built) is only loaded on this same edge.
            state_q    <= plaintext ^ keys[KSCHED_W-1 -: 128];
            rnd_q      <= 4'd1;
            fsm_q      <= S_ROUND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_ROUND: begin
          state_q <= state_d;
          if (rnd_q == LAST_RND) begin
            ct_q        <= state_d;
            rnd_q       <= '0;
            fsm_q       <= S_DONE;
            out_valid_q <= 1'b1;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            fsm_q       <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Testbench for aes_round_engine. A reference model built from GF(2^8)
// arithmetic supplies expected ciphertexts; expected values go into a queue at
// issue time and a monitor compares them whenever the engine hands off a result.
module tb_aes_round_engine;
  typedef logic [0:15][7:0]   blk_t;
  typedef logic [0:10][127:0] sched_t;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic          clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic          in_ready, out_valid, busy;
  logic [127:0]  plaintext = '0, ciphertext;
  logic [1407:0] keys = '0;

  int           n_vec = 0, n_miss = 0;
  logic [127:0] exp_q[$];
  logic [127:0] mon_exp;
  logic [7:0]   sbox_tab [256];

  always #5 clk = ~clk;

  aes_round_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .keys       (keys),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  // ---------------------------------------------------------------- model
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    int p, x, y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if ((y & 1) != 0) p ^= x;
      x = x << 1;
      if ((x & 'h100) != 0) x ^= 'h11b;
      y = y >> 1;
    end
    return p[7:0];
  endfunction

  // S-box = affine map of the multiplicative inverse.
  task automatic build_sbox();
    int inv, s, t;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = y;
      s = inv; t = inv;
      for (int k = 0; k < 4; k++) begin
        t = ((t << 1) | (t >> 7)) & 'hff;
        s ^= t;
      end
      s ^= 'h63;
      sbox_tab[x] = s[7:0];
    end
  endtask

  function automatic sched_t key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    sched_t      ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
            ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  function automatic logic [7:0] mix_coef(input int row, input int k);
    case ((k - row) & 3)
      0:       return 8'h02;
      1:       return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] encrypt(input sched_t ks, input blk_t pt);
    blk_t s, t;
    logic [7:0] acc;
    s = pt ^ ks[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
      t = s;
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row+4*c] = t[row+4*((c+row)%4)];
      if (r != 10) begin
        t = s;
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc ^= gf_mul(mix_coef(row, k), t[k+4*c]);
            s[row+4*c] = acc;
          end
      end
      s = s ^ ks[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------------------------------------------------------- checking
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: wait bound expired without the expected handshake", name);
  endtask

  // Monitor: every hand-off must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail_bound("unexpected_output");
      end else begin
        mon_exp = exp_q.pop_front();
        check("ciphertext", ciphertext, mon_exp);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  // Waits for the engine to be idle, then offers one block; returns just after
  // the accept edge.
  task automatic send(input sched_t ks, input logic [127:0] pt, input logic [127:0] exp);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      fail_bound("accept");
    end else begin
      keys      = ks;
      plaintext = pt;
      in_valid  = 1'b1;
      exp_q.push_back(exp);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // Counts edges after the accept edge up to the first cycle with out_valid=1.
  task automatic wait_out(input string name, input int exp_lat);
    int k;
    bit seen;
    k = 0; seen = 1'b0;
    while (k < 40 && !seen) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      seen = out_valid;
    end
    check(name, 128'(k), 128'(exp_lat));
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      fail_bound(name);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  sched_t       ks1, ks2, ks_r;
  logic [127:0] pt_r;
  bit           bp_done;

  initial begin
    build_sbox();
    ks1 = key_expand(KEY1);
    ks2 = key_expand(KEY2);

    // Reset values
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ciphertext", ciphertext, '0);
    rst_n = 1'b1;

    // Known answers with latency
    send(ks1, PT1, CT1);
    #1 check("busy_in_round", busy, 1);
    wait_out("latency_t1", 10);
    drain("drain_t1");
    send(ks2, PT2, CT2);
    wait_out("latency_t2", 10);
    drain("drain_t2");

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    send(ks1, PT1, CT1);
    wait_out("latency_bp", 10);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_ciphertext", ciphertext, CT1);
      check("hold_in_ready", in_ready, 0);
      check("hold_busy", busy, 1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_ct_kept", ciphertext, CT1);
    if (exp_q.size() != 0) fail_bound("bp_handoff");

    // in_valid during rounds 3..7 is ignored
    send(ks1, PT1, CT1);
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b1;
    plaintext = rand128();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ignore_in_ready", in_ready, 0);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    drain("drain_ignore");
    ks_r = key_expand(rand128());
    pt_r = rand128();
    send(ks_r, pt_r, encrypt(ks_r, pt_r));
    drain("drain_after_ignore");

    // Reset in round 5 discards the block
    send(ks1, PT1, CT1);
    repeat (4) @(posedge clk);
    #2 check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_ciphertext", ciphertext, '0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(ks2, PT2, CT2);
    wait_out("latency_after_rst", 10);
    drain("drain_after_rst");

    // Random blocks with random output stalls
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          ks_r = key_expand(rand128());
          pt_r = rand128();
          send(ks_r, pt_r, encrypt(ks_r, pt_r));
        end
        drain("drain_random");
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    @(posedge clk);
    #1;

`ifdef AES_KEY_LATCH_EN
    // Keys input scrambled after acceptance must not disturb the result
    send(ks1, PT1, CT1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      for (int j = 0; j < 44; j++) keys[32*j +: 32] = $urandom();
    end
    drain("drain_key_latch");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
